general_register_file: RTL and testbench
========================================

Name: general_register_file

Overview:
- Parametrised IA-32 general register file with integrated reg-field decode.
- Resolves the 3-bit register code, operand width (16/32), `w`-field presence and `w` value to a register and byte lane:
  - 8-bit: AL..BH
  - 16-bit: AX..DI
  - 32-bit: EAX..EDI
- Provides N registered read ports and one merging write port.
- Sits between the instruction decode stage and the execute stage. Supplies operands and accepts results.

Parameters:
NUM_READ_PORTS, 2, number of independent read ports (1..4)
BYPASS, 1, 1 = a read in the same cycle as an overlapping write returns the post-write value; 0 = returns the pre-write value
ESP_RESET, 32'h0000_0000, reset value of ESP; every other register resets to 0

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rd_req  in  NUM_READ_PORTS  per-port read request
rd_code  in  3*NUM_READ_PORTS  per-port reg code; port p uses bits [3p+2:3p]
rd_bit_width  in  2*NUM_READ_PORTS  per-port one-hot width: 2'b01 = 16-bit, 2'b10 = 32-bit
rd_w_in_instr  in  NUM_READ_PORTS  per-port: 1 = instruction has a w field
rd_w  in  NUM_READ_PORTS  per-port w bit
rd_data  out  32*NUM_READ_PORTS  per-port read data, zero-extended
rd_valid  out  NUM_READ_PORTS  per-port: rd_data valid this cycle
rd_err  out  NUM_READ_PORTS  per-port: illegal width on the accepted request
wr_en  in  1  write request
wr_code  in  3  write reg code
wr_bit_width  in  2  one-hot write width, same encoding as rd_bit_width
wr_w_in_instr  in  1  1 = instruction has a w field
wr_w  in  1  w bit
wr_data  in  32  write data; only the selected lane is used
wr_err  out  1  illegal width on the write issued in the previous cycle

Behaviour:
- Storage: eight 32-bit registers, index 0..7 = EAX, ECX, EDX, EBX, ESP, EBP, ESI, EDI.
- Size resolution, identical for read and write:
  - w_in_instr = 0: size taken from bit_width (16 or 32).
  - w_in_instr = 1 and w = 0: 8-bit.
  - w_in_instr = 1 and w = 1: size taken from bit_width.
  - bit_width not in {01, 10} is illegal. This applies even when the resolved size is 8-bit.
- Lane mapping:
  - 32-bit: whole register[code].
  - 16-bit: register[code][15:0].
  - 8-bit, codes 0-3: register[code][7:0] (AL, CL, DL, BL).
  - 8-bit, codes 4-7: register[code-4][15:8] (AH, CH, DH, BH).
- Write:
  - Legal write with wr_en = 1 updates only the selected lane at the clock edge.
  - All other bits of the target register and all other registers are unchanged.
  - Data source is the low 8/16/32 bits of wr_data.
- Illegal write: no register changes; wr_err = 1 in the next cycle.
- wr_err is 0 in any cycle following wr_en = 0.
- Read:
  - Latency is 1 cycle. rd_req in cycle t produces rd_valid = 1 and rd_data in cycle t+1.
  - rd_data holds the selected lane zero-extended to 32 bits.
  - Read ports are fully independent. Any number may address the same register.
- Illegal read: rd_valid = 1, rd_err = 1, rd_data = 0 in cycle t+1.
- With rd_req = 0:
  - rd_valid = 0 and rd_err = 0 next cycle.
  - rd_data holds its last value.
- Same-cycle read/write to the same register:
  - BYPASS = 1: rd_data reflects the merged post-write register value, even when the read lane differs from the write lane (e.g. write AH, read AX).
  - BYPASS = 0: rd_data reflects the pre-write value.
  - Bypass applies only to legal writes.
- Reset:
  - While rst = 1, all registers load reset values (ESP = ESP_RESET, others 0).
  - rd_data = 0, rd_valid = 0, rd_err = 0, wr_err = 0.
  - Reset has priority over any concurrent write or read.
  - A read issued in the cycle rst deasserts is serviced normally.
- No back-pressure. A read is accepted every cycle on every port; a write is accepted every cycle.

Test Plan:
1. Reset, then write EAX = 32'h1122_3344 (wr_bit_width = 10, w_in_instr = 0). Next cycle read AL, AH, AX, EAX → 32'h44, 32'h33, 32'h3344, 32'h1122_3344.
2. Write BH = 8'hAB (code 7, w_in_instr = 1, w = 0, bit_width = 01) to a zero EBX. Next cycle read EBX → 32'h0000_AB00; EDI unchanged at 0.
3. BYPASS = 1, EDX = 0. In one cycle write DX = 16'hBEEF and read EDX → 32'h0000_BEEF one cycle later. Repeat with BYPASS = 0 → 32'h0000_0000.
4. Write with wr_bit_width = 2'b11 → wr_err = 1 next cycle, all registers unchanged. Read with rd_bit_width = 2'b00 → rd_valid = 1, rd_err = 1, rd_data = 0.
5. NUM_READ_PORTS = 2: both ports read ESP in the same cycle after reset with ESP_RESET = 32'h0000_FFFC → both return 32'h0000_FFFC. Assert rst simultaneously with a write of EAX = 1 → EAX remains 0.
6. Back-to-back writes ECX = 32'hFFFF_FFFF then CL = 8'h00 on consecutive cycles, reading ECX each cycle (BYPASS = 1) → 32'hFFFF_FFFF, then 32'hFFFF_FF00.

Source files
------------

// File: rtl/general_register_file.sv
// -----------------------------------------------------------------------------
// general_register_file
//
// IA-32 general register file (EAX..EDI) with the reg-field decode folded in.
// Each access names a 3-bit register code plus the operand width, the presence
// of a w field and the w bit. These resolve to a register and a byte lane:
// 8-bit (AL..BH), 16-bit (AX..DI) or 32-bit (EAX..EDI).
// The file offers NUM_READ_PORTS registered read ports and one write port.
// The write port merges the selected lane into the target register.
//
// Parameters
//   NUM_READ_PORTS  number of independent read ports (1..4)
//   BYPASS          1: a read that overlaps a same-cycle legal write sees the
//                   merged post-write register; 0: it sees the pre-write value
//   ESP_RESET       reset value of ESP (all other registers reset to 0)
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   rd_req          per-port read request
//   rd_code         per-port register code, port p at [3p+2:3p]
//   rd_bit_width    per-port one-hot width (01 = 16-bit, 10 = 32-bit)
//   rd_w_in_instr   per-port: instruction carries a w field
//   rd_w            per-port w bit
//   rd_data         per-port read data (zero-extended lane), one cycle later
//   rd_valid        per-port: rd_data produced by a request last cycle
//   rd_err          per-port: that request had an illegal width
//   wr_en           write request
//   wr_code         write register code
//   wr_bit_width    one-hot write width
//   wr_w_in_instr   write instruction carries a w field
//   wr_w            write w bit
//   wr_data         write data, low 8/16/32 bits used
//   wr_err          the write issued last cycle had an illegal width
// -----------------------------------------------------------------------------
module general_register_file #(
   parameter int          NUM_READ_PORTS = 2,
   parameter bit          BYPASS         = 1'b1,
   parameter logic [31:0] ESP_RESET      = 32'h0000_0000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_READ_PORTS-1:0]     rd_req,
   input  logic [3*NUM_READ_PORTS-1:0]   rd_code,
   input  logic [2*NUM_READ_PORTS-1:0]   rd_bit_width,
   input  logic [NUM_READ_PORTS-1:0]     rd_w_in_instr,
   input  logic [NUM_READ_PORTS-1:0]     rd_w,
   output logic [32*NUM_READ_PORTS-1:0]  rd_data,
   output logic [NUM_READ_PORTS-1:0]     rd_valid,
   output logic [NUM_READ_PORTS-1:0]     rd_err,
   input  logic                          wr_en,
   input  logic [2:0]                    wr_code,
   input  logic [1:0]                    wr_bit_width,
   input  logic                          wr_w_in_instr,
   input  logic                          wr_w,
   input  logic [31:0]                   wr_data,
   output logic                          wr_err
);

   typedef enum logic [1:0] {
      SIZE_8  = 2'd0,
      SIZE_16 = 2'd1,
      SIZE_32 = 2'd2
   } size_e;

   localparam int ESP_INDEX = 4;

   // A cleared w bit forces a byte access; otherwise the one-hot width decides.
   function automatic size_e resolve_size(input logic [1:0] bit_width,
                                          input logic       w_in_instr,
                                          input logic       w);
      size_e size;
      if (w_in_instr && !w)
         size = SIZE_8;
      else if (bit_width == 2'b10)
         size = SIZE_32;
      else
         size = SIZE_16;
      return size;
   endfunction

   // Only the two one-hot encodings are legal, even for byte accesses.
   function automatic logic width_legal(input logic [1:0] bit_width);
      return (bit_width == 2'b01) || (bit_width == 2'b10);
   endfunction

   // Byte codes 4..7 (AH..BH) live in the second byte of registers 0..3.
   function automatic logic [2:0] resolve_index(input logic [2:0] code,
                                                input size_e      size);
      return (size == SIZE_8) ? {1'b0, code[1:0]} : code;
   endfunction

   function automatic logic high_byte(input logic [2:0] code, input size_e size);
      return (size == SIZE_8) && code[2];
   endfunction

   function automatic logic [31:0] extract_lane(input logic [31:0] value,
                                                input size_e       size,
                                                input logic        hi);
      logic [31:0] lane;
      case (size)
         SIZE_32: lane = value;
         SIZE_16: lane = {16'h0, value[15:0]};
         SIZE_8:  lane = hi ? {24'h0, value[15:8]} : {24'h0, value[7:0]};
         default: lane = 32'h0;
      endcase
      return lane;
   endfunction

   function automatic logic [31:0] merge_lane(input logic [31:0] old_value,
                                              input logic [31:0] data,
                                              input size_e       size,
                                              input logic        hi);
      logic [31:0] merged;
      case (size)
         SIZE_32: merged = data;
         SIZE_16: merged = {old_value[31:16], data[15:0]};
         SIZE_8:  merged = hi ? {old_value[31:16], data[7:0], old_value[7:0]}
                              : {old_value[31:8], data[7:0]};
         default: merged = old_value;
      endcase
      return merged;
   endfunction

   logic [31:0] regs [8];

   size_e       wr_size;
   logic        wr_legal;
   logic [2:0]  wr_index;
   logic        wr_high;
   logic [31:0] wr_merged;

   size_e       rd_size  [NUM_READ_PORTS];
   logic [2:0]  rd_index [NUM_READ_PORTS];
   logic [31:0] rd_src   [NUM_READ_PORTS];
   logic [31:0] rd_lane  [NUM_READ_PORTS];
   logic        rd_legal [NUM_READ_PORTS];

   // Write decode: the full merged register value is built here so the
   // register update and the read bypass share one definition of the result.
   always_comb begin
      wr_size   = resolve_size(wr_bit_width, wr_w_in_instr, wr_w);
      wr_legal  = wr_en && width_legal(wr_bit_width);
      wr_index  = resolve_index(wr_code, wr_size);
      wr_high   = high_byte(wr_code, wr_size);
      wr_merged = merge_lane(regs[wr_index], wr_data, wr_size, wr_high);
   end

   // Read decode per port. Bypass compares register indices rather than
   // lanes, so a read of AX sees a same-cycle write of AH.
   always_comb begin
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
         rd_size[p]  = resolve_size(rd_bit_width[2*p +: 2], rd_w_in_instr[p], rd_w[p]);
         rd_index[p] = resolve_index(rd_code[3*p +: 3], rd_size[p]);
         rd_legal[p] = width_legal(rd_bit_width[2*p +: 2]);
         rd_src[p]   = (BYPASS && wr_legal && (wr_index == rd_index[p]))
                       ? wr_merged : regs[rd_index[p]];
         rd_lane[p]  = rd_legal[p]
                       ? extract_lane(rd_src[p], rd_size[p],
                                      high_byte(rd_code[3*p +: 3], rd_size[p]))
                       : 32'h0;
      end
   end

   // Register storage: reset wins over any concurrent write, and an illegal
   // write leaves every register untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++)
            regs[i] <= (i == ESP_INDEX) ? ESP_RESET : 32'h0;
      end else if (wr_legal) begin
         regs[wr_index] <= wr_merged;
      end
   end

   // Write error flag reports on the cycle after the offending write.
   always_ff @(posedge clk) begin
      if (rst)
         wr_err <= 1'b0;
      else
         wr_err <= wr_en && !width_legal(wr_bit_width);
   end

   // Read result registers: data holds its last value when a port is idle,
   // while valid and error drop back to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= '0;
         rd_err   <= '0;
      end else begin
         for (int p = 0; p < NUM_READ_PORTS; p++) begin
            if (rd_req[p]) begin
               rd_data[32*p +: 32] <= rd_lane[p];
               rd_valid[p]         <= 1'b1;
               rd_err[p]           <= !rd_legal[p];
            end else begin
               rd_valid[p]         <= 1'b0;
               rd_err[p]           <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_general_register_file.sv
// -----------------------------------------------------------------------------
// tb_general_register_file
//
// Drives two general_register_file instances from the same stimulus: one
// with BYPASS = 1 and one with BYPASS = 0 (both with ESP_RESET = 32'h0000_FFFC
// and two read ports). Directed scenarios check fixed register values.
// A randomized phase checks every output against a byte-lane model. The model
// works on plain shift/mask arithmetic over an array of eight registers.
// -----------------------------------------------------------------------------
module tb_general_register_file;

   localparam logic [31:0] ESP_RST = 32'h0000_FFFC;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  rd_req;
   logic [5:0]  rd_code;
   logic [3:0]  rd_bit_width;
   logic [1:0]  rd_w_in_instr;
   logic [1:0]  rd_w;
   logic        wr_en;
   logic [2:0]  wr_code;
   logic [1:0]  wr_bit_width;
   logic        wr_w_in_instr;
   logic        wr_w;
   logic [31:0] wr_data;

   logic [63:0] rd_data_b, rd_data_n;
   logic [1:0]  rd_valid_b, rd_valid_n, rd_err_b, rd_err_n;
   logic        wr_err_b, wr_err_n;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state and the expectations for the cycle just clocked.
   logic [31:0] mregs [8];
   logic [31:0] exp_b [2];
   logic [31:0] exp_n [2];
   logic [1:0]  exp_valid, exp_err;
   logic        exp_wr_err;

   always #5 clk = ~clk;

   general_register_file #(.NUM_READ_PORTS(2), .BYPASS(1'b1), .ESP_RESET(ESP_RST)) dut_byp (
      .clk(clk), .rst(rst), .rd_req(rd_req), .rd_code(rd_code),
      .rd_bit_width(rd_bit_width), .rd_w_in_instr(rd_w_in_instr), .rd_w(rd_w),
      .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_err(rd_err_b),
      .wr_en(wr_en), .wr_code(wr_code), .wr_bit_width(wr_bit_width),
      .wr_w_in_instr(wr_w_in_instr), .wr_w(wr_w), .wr_data(wr_data), .wr_err(wr_err_b));

   general_register_file #(.NUM_READ_PORTS(2), .BYPASS(1'b0), .ESP_RESET(ESP_RST)) dut_nobyp (
      .clk(clk), .rst(rst), .rd_req(rd_req), .rd_code(rd_code),
      .rd_bit_width(rd_bit_width), .rd_w_in_instr(rd_w_in_instr), .rd_w(rd_w),
      .rd_data(rd_data_n), .rd_valid(rd_valid_n), .rd_err(rd_err_n),
      .wr_en(wr_en), .wr_code(wr_code), .wr_bit_width(wr_bit_width),
      .wr_w_in_instr(wr_w_in_instr), .wr_w(wr_w), .wr_data(wr_data), .wr_err(wr_err_n));

   // Model helpers: access size in bytes, legality, mask, register and shift.
   function automatic int size_bytes(input logic w_in, input logic w, input logic [1:0] bw);
      if (w_in && !w) return 1;
      return (bw == 2'b10) ? 4 : 2;
   endfunction

   function automatic bit is_legal(input logic [1:0] bw);
      return (bw == 2'b01) || (bw == 2'b10);
   endfunction

   function automatic logic [31:0] lane_mask(input int bytes);
      if (bytes == 4) return 32'hFFFF_FFFF;
      return (32'h1 << (8 * bytes)) - 32'h1;
   endfunction

   function automatic int target_reg(input int code, input int bytes);
      return (bytes == 1) ? code % 4 : code;
   endfunction

   function automatic int lane_shift(input int code, input int bytes);
      return (bytes == 1 && code >= 4) ? 8 : 0;
   endfunction

   task automatic clear_inputs();
      rst = 1'b0; rd_req = '0; rd_code = '0; rd_bit_width = '0;
      rd_w_in_instr = '0; rd_w = '0; wr_en = 1'b0; wr_code = '0;
      wr_bit_width = '0; wr_w_in_instr = 1'b0; wr_w = 1'b0; wr_data = '0;
   endtask

   task automatic set_rd(input int p, input logic [2:0] code, input logic [1:0] bw,
                         input logic w_in, input logic w);
      rd_req[p] = 1'b1;
      rd_code[3*p +: 3] = code;
      rd_bit_width[2*p +: 2] = bw;
      rd_w_in_instr[p] = w_in;
      rd_w[p] = w;
   endtask

   task automatic set_wr(input logic [2:0] code, input logic [1:0] bw,
                         input logic w_in, input logic w, input logic [31:0] data);
      wr_en = 1'b1; wr_code = code; wr_bit_width = bw;
      wr_w_in_instr = w_in; wr_w = w; wr_data = data;
   endtask

   // Advance the model by one cycle from the currently driven inputs, then
   // clock the DUTs and settle just past the edge.
   task automatic step();
      logic [31:0] post [8];
      int wb, wt, ws, rb, rt, rs;
      post = mregs;
      wb = size_bytes(wr_w_in_instr, wr_w, wr_bit_width);
      if (!rst && wr_en && is_legal(wr_bit_width)) begin
         wt = target_reg(int'(wr_code), wb);
         ws = lane_shift(int'(wr_code), wb);
         post[wt] = (post[wt] & ~(lane_mask(wb) << ws)) | ((wr_data & lane_mask(wb)) << ws);
      end
      for (int p = 0; p < 2; p++) begin
         if (rst) begin
            exp_b[p] = 32'h0; exp_n[p] = 32'h0;
            exp_valid[p] = 1'b0; exp_err[p] = 1'b0;
         end else if (rd_req[p]) begin
            exp_valid[p] = 1'b1;
            exp_err[p] = !is_legal(rd_bit_width[2*p +: 2]);
            if (exp_err[p]) begin
               exp_b[p] = 32'h0; exp_n[p] = 32'h0;
            end else begin
               rb = size_bytes(rd_w_in_instr[p], rd_w[p], rd_bit_width[2*p +: 2]);
               rt = target_reg(int'(rd_code[3*p +: 3]), rb);
               rs = lane_shift(int'(rd_code[3*p +: 3]), rb);
               exp_b[p] = (post[rt] >> rs) & lane_mask(rb);
               exp_n[p] = (mregs[rt] >> rs) & lane_mask(rb);
            end
         end else begin
            exp_valid[p] = 1'b0; exp_err[p] = 1'b0;
         end
      end
      exp_wr_err = !rst && wr_en && !is_legal(wr_bit_width);
      if (rst) begin
         for (int i = 0; i < 8; i++) mregs[i] = (i == 4) ? ESP_RST : 32'h0;
      end else begin
         mregs = post;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clear_inputs(); rst = 1'b1;
      step();
      n_checks++;
      if ({rd_data_b, rd_valid_b, rd_err_b, wr_err_b} !== '0) begin
         n_fail++; $display("[TB] FAIL reset_outputs_byp: got %h/%b/%b/%b, expected all zero", rd_data_b, rd_valid_b, rd_err_b, wr_err_b);
      end
      // Reset held together with a write of EAX = 1 and a read request.
      set_wr(3'd0, 2'b10, 1'b0, 1'b0, 32'h1);
      set_rd(0, 3'd4, 2'b10, 1'b0, 1'b0);
      step();
      n_checks++;
      if ({rd_data_n, rd_valid_n, rd_err_n, wr_err_n} !== '0) begin
         n_fail++; $display("[TB] FAIL reset_priority_nobyp: got %h/%b/%b/%b, expected all zero", rd_data_n, rd_valid_n, rd_err_n, wr_err_n);
      end
      // Both ports read ESP in the cycle reset drops.
      clear_inputs();
      set_rd(0, 3'd4, 2'b10, 1'b0, 1'b0);
      set_rd(1, 3'd4, 2'b10, 1'b0, 1'b0);
      step();
      n_checks++;
      if (rd_data_b !== {ESP_RST, ESP_RST} || rd_valid_b !== 2'b11 || rd_err_b !== 2'b00) begin
         n_fail++; $display("[TB] FAIL esp_reset_byp: got %h v=%b e=%b, expected %h v=11 e=00", rd_data_b, rd_valid_b, rd_err_b, {ESP_RST, ESP_RST});
      end
      n_checks++;
      if (rd_data_n !== {ESP_RST, ESP_RST}) begin
         n_fail++; $display("[TB] FAIL esp_reset_nobyp: got %h, expected %h", rd_data_n, {ESP_RST, ESP_RST});
      end
      clear_inputs();
      set_rd(0, 3'd0, 2'b10, 1'b0, 1'b0);
      step();
      n_checks++;
      if (rd_data_b[31:0] !== 32'h0 || rd_valid_b !== 2'b01) begin
         n_fail++; $display("[TB] FAIL eax_after_reset: got %h v=%b, expected 00000000 v=01", rd_data_b[31:0], rd_valid_b);
      end
   endtask

   task automatic test_lanes();
      clear_inputs();
      set_wr(3'd0, 2'b10, 1'b0, 1'b0, 32'h1122_3344);
      step();
      clear_inputs();
      set_rd(0, 3'd0, 2'b01, 1'b1, 1'b0);
      set_rd(1, 3'd4, 2'b01, 1'b1, 1'b0);
      step();
      n_checks++;
      if (rd_data_b !== {32'h33, 32'h44} || rd_data_n !== {32'h33, 32'h44}) begin
         n_fail++; $display("[TB] FAIL read_al_ah: got %h / %h, expected %h", rd_data_b, rd_data_n, {32'h33, 32'h44});
      end
      clear_inputs();
      set_rd(0, 3'd0, 2'b01, 1'b0, 1'b0);
      set_rd(1, 3'd0, 2'b10, 1'b0, 1'b0);
      step();
      n_checks++;
      if (rd_data_b !== {32'h1122_3344, 32'h3344} || rd_data_n !== {32'h1122_3344, 32'h3344}) begin
         n_fail++; $display("[TB] FAIL read_ax_eax: got %h / %h, expected %h", rd_data_b, rd_data_n, {32'h1122_3344, 32'h3344});
      end
      clear_inputs();
      set_rd(0, 3'd0, 2'b10, 1'b1, 1'b1);
      set_rd(1, 3'd0, 2'b01, 1'b1, 1'b1);
      step();
      n_checks++;
      if (rd_data_b !== {32'h3344, 32'h1122_3344}) begin
         n_fail++; $display("[TB] FAIL read_w1_sizes: got %h, expected %h", rd_data_b, {32'h3344, 32'h1122_3344});
      end
   endtask

   task automatic test_high_byte();
      clear_inputs();
      set_wr(3'd7, 2'b01, 1'b1, 1'b0, 32'hFFFF_FFAB);
      step();
      clear_inputs();
      set_rd(0, 3'd3, 2'b10, 1'b0, 1'b0);
      set_rd(1, 3'd7, 2'b10, 1'b0, 1'b0);
      step();
      n_checks++;
      if (rd_data_b !== {32'h0, 32'h0000_AB00} || rd_data_n !== {32'h0, 32'h0000_AB00}) begin
         n_fail++; $display("[TB] FAIL write_bh: got %h / %h, expected %h", rd_data_b, rd_data_n, {32'h0, 32'h0000_AB00});
      end
   endtask

   task automatic test_bypass();
      clear_inputs();
      set_wr(3'd2, 2'b01, 1'b0, 1'b0, 32'h1234_BEEF);
      set_rd(0, 3'd2, 2'b10, 1'b0, 1'b0);
      step();
      n_checks++;
      if (rd_data_b[31:0] !== 32'h0000_BEEF) begin
         n_fail++; $display("[TB] FAIL bypass_dx_byp: got %h, expected 0000beef", rd_data_b[31:0]);
      end
      n_checks++;
      if (rd_data_n[31:0] !== 32'h0) begin
         n_fail++; $display("[TB] FAIL bypass_dx_nobyp: got %h, expected 00000000", rd_data_n[31:0]);
      end
      // Write AH while reading AX and EDX in the same cycle.
      clear_inputs();
      set_wr(3'd4, 2'b01, 1'b1, 1'b0, 32'h0000_005A);
      set_rd(0, 3'd0, 2'b01, 1'b0, 1'b0);
      set_rd(1, 3'd2, 2'b10, 1'b0, 1'b0);
      step();
      n_checks++;
      if (rd_data_b !== {32'h0000_BEEF, 32'h0000_5A44}) begin
         n_fail++; $display("[TB] FAIL bypass_ah_ax_byp: got %h, expected %h", rd_data_b, {32'h0000_BEEF, 32'h0000_5A44});
      end
      n_checks++;
      if (rd_data_n !== {32'h0000_BEEF, 32'h0000_3344}) begin
         n_fail++; $display("[TB] FAIL bypass_ah_ax_nobyp: got %h, expected %h", rd_data_n, {32'h0000_BEEF, 32'h0000_3344});
      end
   endtask

   task automatic test_illegal();
      clear_inputs();
      set_wr(3'd0, 2'b11, 1'b0, 1'b0, 32'hFFFF_FFFF);
      set_rd(0, 3'd0, 2'b10, 1'b0, 1'b0);
      step();
      n_checks++;
      if (wr_err_b !== 1'b1 || wr_err_n !== 1'b1) begin
         n_fail++; $display("[TB] FAIL illegal_write_err: got %b/%b, expected 1/1", wr_err_b, wr_err_n);
      end
      n_checks++;
      if (rd_data_b[31:0] !== 32'h1122_5A44 || rd_data_n[31:0] !== 32'h1122_5A44) begin
         n_fail++; $display("[TB] FAIL illegal_write_no_bypass: got %h/%h, expected 11225a44", rd_data_b[31:0], rd_data_n[31:0]);
      end
      // Byte-sized write with an illegal width, plus an illegal read.
      clear_inputs();
      set_wr(3'd3, 2'b00, 1'b1, 1'b0, 32'h0000_00FF);
      set_rd(0, 3'd3, 2'b10, 1'b0, 1'b0);
      set_rd(1, 3'd0, 2'b00, 1'b0, 1'b0);
      step();
      n_checks++;
      if (wr_err_b !== 1'b1 || rd_valid_b !== 2'b11 || rd_err_b !== 2'b10 || rd_data_b[63:32] !== 32'h0) begin
         n_fail++; $display("[TB] FAIL illegal_read: got werr=%b v=%b e=%b d1=%h, expected 1/11/10/00000000", wr_err_b, rd_valid_b, rd_err_b, rd_data_b[63:32]);
      end
      clear_inputs();
      set_rd(0, 3'd3, 2'b10, 1'b0, 1'b0);
      set_rd(1, 3'd0, 2'b11, 1'b1, 1'b0);
      step();
      n_checks++;
      if (wr_err_n !== 1'b0 || rd_data_n[31:0] !== 32'h0000_AB00) begin
         n_fail++; $display("[TB] FAIL illegal_write_unchanged: got werr=%b ebx=%h, expected 0/0000ab00", wr_err_n, rd_data_n[31:0]);
      end
      n_checks++;
      if (rd_err_n !== 2'b10 || rd_valid_n !== 2'b11 || rd_data_n[63:32] !== 32'h0) begin
         n_fail++; $display("[TB] FAIL illegal_read_byte: got v=%b e=%b d1=%h, expected 11/10/00000000", rd_valid_n, rd_err_n, rd_data_n[63:32]);
      end
   endtask

   task automatic test_back_to_back();
      clear_inputs();
      set_wr(3'd1, 2'b10, 1'b0, 1'b0, 32'hFFFF_FFFF);
      set_rd(0, 3'd1, 2'b10, 1'b0, 1'b0);
      step();
      n_checks++;
      if (rd_data_b[31:0] !== 32'hFFFF_FFFF || rd_data_n[31:0] !== 32'h0) begin
         n_fail++; $display("[TB] FAIL b2b_first: got %h/%h, expected ffffffff/00000000", rd_data_b[31:0], rd_data_n[31:0]);
      end
      clear_inputs();
      set_wr(3'd1, 2'b01, 1'b1, 1'b0, 32'h0);
      set_rd(0, 3'd1, 2'b10, 1'b0, 1'b0);
      step();
      n_checks++;
      if (rd_data_b[31:0] !== 32'hFFFF_FF00 || rd_data_n[31:0] !== 32'hFFFF_FFFF) begin
         n_fail++; $display("[TB] FAIL b2b_second: got %h/%h, expected ffffff00/ffffffff", rd_data_b[31:0], rd_data_n[31:0]);
      end
      clear_inputs();
      step();
      n_checks++;
      if (rd_valid_b !== 2'b00 || rd_err_b !== 2'b00 || rd_data_b[31:0] !== 32'hFFFF_FF00) begin
         n_fail++; $display("[TB] FAIL idle_hold: got v=%b e=%b d0=%h, expected 00/00/ffffff00", rd_valid_b, rd_err_b, rd_data_b[31:0]);
      end
   endtask

   task automatic test_random();
      logic [1:0] bw_pick [4];
      bw_pick[0] = 2'b01; bw_pick[1] = 2'b10; bw_pick[2] = 2'b00; bw_pick[3] = 2'b11;
      for (int cyc = 0; cyc < 400; cyc++) begin
         clear_inputs();
         rst = ($urandom_range(0, 49) == 0);
         wr_en = 1'($urandom_range(0, 1));
         wr_code = 3'($urandom_range(0, 7));
         wr_bit_width = bw_pick[($urandom_range(0, 9) < 8) ? $urandom_range(0, 1) : $urandom_range(2, 3)];
         wr_w_in_instr = 1'($urandom_range(0, 1));
         wr_w = 1'($urandom_range(0, 1));
         wr_data = $urandom;
         for (int p = 0; p < 2; p++) begin
            rd_req[p] = ($urandom_range(0, 3) != 0);
            rd_code[3*p +: 3] = ($urandom_range(0, 1) == 1) ? wr_code : 3'($urandom_range(0, 7));
            rd_bit_width[2*p +: 2] = bw_pick[($urandom_range(0, 9) < 8) ? $urandom_range(0, 1) : $urandom_range(2, 3)];
            rd_w_in_instr[p] = 1'($urandom_range(0, 1));
            rd_w[p] = 1'($urandom_range(0, 1));
         end
         step();
         n_checks++;
         if (rd_data_b !== {exp_b[1], exp_b[0]}) begin
            n_fail++; $display("[TB] FAIL rand_data_byp cycle %0d: got %h, expected %h", cyc, rd_data_b, {exp_b[1], exp_b[0]});
         end
         n_checks++;
         if (rd_data_n !== {exp_n[1], exp_n[0]}) begin
            n_fail++; $display("[TB] FAIL rand_data_nobyp cycle %0d: got %h, expected %h", cyc, rd_data_n, {exp_n[1], exp_n[0]});
         end
         n_checks++;
         if ({rd_valid_b, rd_err_b, wr_err_b} !== {exp_valid, exp_err, exp_wr_err}) begin
            n_fail++; $display("[TB] FAIL rand_flags_byp cycle %0d: got %b, expected %b", cyc, {rd_valid_b, rd_err_b, wr_err_b}, {exp_valid, exp_err, exp_wr_err});
         end
         n_checks++;
         if ({rd_valid_n, rd_err_n, wr_err_n} !== {exp_valid, exp_err, exp_wr_err}) begin
            n_fail++; $display("[TB] FAIL rand_flags_nobyp cycle %0d: got %b, expected %b", cyc, {rd_valid_n, rd_err_n, wr_err_n}, {exp_valid, exp_err, exp_wr_err});
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      clear_inputs();
      test_reset();
      test_lanes();
      test_high_byte();
      test_bypass();
      test_illegal();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
